// File: rtl/fpu_itof_seq.sv
// Multi-cycle signed int32 -> float32 converter: captures magnitude/sign,
// normalises with a bounded per-cycle left shifter, then rounds per RM_SI.
`timescale 1ns/1ps
module fpu_itof_seq #(
  parameter int unsigned C_OP         = 32,
  parameter int unsigned C_MANT       = 23,
  parameter int unsigned C_EXP        = 8,
  parameter int unsigned C_RM         = 2,
  parameter int unsigned C_SHIFT_STEP = 4,
  parameter int unsigned C_EXP_START  = 158
) (
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  input  logic              Valid_SI,
  output logic              Ready_SO,
  input  logic [C_OP-1:0]   Operand_a_DI,
  input  logic [C_RM-1:0]   RM_SI,
  input  logic              Flush_SI,
  output logic              Valid_SO,
  input  logic              Ready_SI,
  output logic [C_OP-1:0]   Result_DO,
  output logic              Inexact_SO,
  output logic              Busy_SO
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  localparam int unsigned LZW = 4;

  state_t            state_q, state_d;
  logic [C_OP-1:0]   mag_q, mag_d;
  logic [C_EXP-1:0]  exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [C_RM-1:0]   rm_q, rm_d;
  logic [C_OP-1:0]   result_q, result_d;
  logic              inexact_q, inexact_d;

  logic [C_OP-1:0]   mag_in;
  logic [LZW-1:0]    lz;
  logic              lz_found;

  logic [C_MANT-1:0] mant_raw;
  logic [C_MANT:0]   mant_sum;
  logic [C_EXP-1:0]  exp_rnd;
  logic              guard, sticky, round_up;

  assign mag_in = Operand_a_DI[C_OP-1] ? (~Operand_a_DI + C_OP'(1)) : Operand_a_DI;

  // Leading-zero count limited to the top C_SHIFT_STEP bits; an all-zero field
  // yields the full step so wide gaps close over several NORM cycles.
  always_comb begin
    lz       = LZW'(C_SHIFT_STEP);
    lz_found = 1'b0;
    for (int unsigned i = 0; i < C_SHIFT_STEP; i++) begin
      if (!lz_found && mag_q[C_OP-1-i]) begin
        lz       = LZW'(i);
        lz_found = 1'b1;
      end
    end
  end

  always_comb begin
    mant_raw = mag_q[C_OP-2 -: C_MANT];
    guard    = mag_q[C_OP-2-C_MANT];
    sticky   = |mag_q[C_OP-3-C_MANT:0];
    case (rm_q)
      2'd0:    round_up = guard && (sticky || mant_raw[0]);
      2'd1:    round_up = 1'b0;
      2'd2:    round_up = !sign_q && (guard || sticky);
      default: round_up = sign_q && (guard || sticky);
    endcase
    mant_sum = {1'b0, mant_raw} + (C_MANT+1)'(round_up);
    // Mantissa carry-out leaves the low bits zero and bumps the exponent.
    exp_rnd  = exp_q + C_EXP'(mant_sum[C_MANT]);
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    rm_d      = rm_q;
    result_d  = result_q;
    inexact_d = inexact_q;
    if (Flush_SI) begin
      state_d   = IDLE;
      inexact_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Valid_SI) begin
            sign_d  = Operand_a_DI[C_OP-1];
            mag_d   = mag_in;
            exp_d   = C_EXP'(C_EXP_START);
            rm_d    = RM_SI;
            state_d = (mag_in == '0) ? ROUND : NORM;
          end
        end
        NORM: begin
          if (mag_q[C_OP-1]) begin
            state_d = ROUND;
          end else begin
            mag_d = mag_q << lz;
            exp_d = exp_q - C_EXP'(lz);
          end
        end
        ROUND: begin
          if (mag_q == '0) begin
            result_d  = '0;
            inexact_d = 1'b0;
          end else begin
            result_d  = {sign_q, exp_rnd, mant_sum[C_MANT-1:0]};
            inexact_d = guard || sticky;
          end
          state_d = DONE;
        end
        DONE: begin
          if (Ready_SI) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      rm_q      <= '0;
      result_q  <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      rm_q      <= rm_d;
      result_q  <= result_d;
      inexact_q <= inexact_d;
    end
  end

  assign Ready_SO   = (state_q == IDLE) && !Flush_SI;
  assign Valid_SO   = (state_q == DONE);
  assign Busy_SO    = (state_q != IDLE);
  assign Result_DO  = result_q;
  assign Inexact_SO = inexact_q;

endmodule

// File: tb/tb_fpu_itof_seq.sv
// Bench for fpu_itof_seq: directed table, randomized model comparison,
// back-pressure, flush and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_fpu_itof_seq;

  logic        Clk_CI = 1'b0;
  logic        Rst_RBI = 1'b0;
  logic        Valid_SI = 1'b0;
  logic        Ready_SO;
  logic [31:0] Operand_a_DI = '0;
  logic [1:0]  RM_SI = '0;
  logic        Flush_SI = 1'b0;
  logic        Valid_SO;
  logic        Ready_SI = 1'b1;
  logic [31:0] Result_DO;
  logic        Inexact_SO;
  logic        Busy_SO;

  int passed = 0;
  int total  = 0;

  fpu_itof_seq #(.C_SHIFT_STEP(4), .C_EXP_START(158)) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Valid_SI(Valid_SI), .Ready_SO(Ready_SO),
    .Operand_a_DI(Operand_a_DI), .RM_SI(RM_SI), .Flush_SI(Flush_SI),
    .Valid_SO(Valid_SO), .Ready_SI(Ready_SI), .Result_DO(Result_DO),
    .Inexact_SO(Inexact_SO), .Busy_SO(Busy_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endfunction

  // Reference: exact integer arithmetic on the magnitude, rounding decided from
  // the discarded remainder against the half-ulp.
  function automatic void model(input logic [31:0] op, input logic [1:0] rm,
                                output logic [31:0] res, output logic inx, output int lat);
    longint unsigned mag, q, rem, half;
    int p, e, sh, lzc;
    logic sgn, up;
    sgn = op[31];
    mag = sgn ? longint'(33'h100000000 - {1'b0, op}) : longint'(op);
    if (mag == 0) begin
      res = '0; inx = 1'b0; lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (mag >= (64'd1 << i)) p = i;
    lzc = 31 - p;
    lat = (lzc + 3) / 4 + 3;
    if (p <= 23) begin
      q = mag << (23 - p); rem = 0; half = 1;
    end else begin
      sh = p - 23;
      q = mag >> sh;
      rem = mag - (q << sh);
      half = 64'd1 << (sh - 1);
    end
    case (rm)
      2'd0: up = (rem > half) || (rem == half && q[0]);
      2'd1: up = 1'b0;
      2'd2: up = !sgn && rem != 0;
      default: up = sgn && rem != 0;
    endcase
    q = q + longint'(up);
    e = 127 + p;
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    res = {sgn, 8'(e), q[22:0]};
    inx = (rem != 0);
  endfunction

  // Caller is aligned #1 after a rising edge with the DUT idle.
  task automatic convert(input logic [31:0] op, input logic [1:0] rm,
                         output logic [31:0] res, output logic inx, output int lat,
                         output bit busy_ok);
    int c;
    Operand_a_DI = op; RM_SI = rm; Valid_SI = 1'b1;
    @(posedge Clk_CI); #1;
    Valid_SI = 1'b0; Operand_a_DI = $urandom; RM_SI = 2'($urandom);
    lat = 0; busy_ok = 1; c = 1;
    while (lat == 0 && c <= 40) begin
      if (!Busy_SO) busy_ok = 0;
      if (Valid_SO) lat = c;
      else begin @(posedge Clk_CI); #1; c++; end
    end
    res = Result_DO; inx = Inexact_SO;
    if (Ready_SI && lat != 0) begin @(posedge Clk_CI); #1; end
  endtask

  typedef struct {
    logic [31:0] op;
    logic [1:0]  rm;
    logic [31:0] res;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r, prev;
    logic        x, mx;
    logic [31:0] mr;
    int          l, ml, stable_bad;
    bit          bok;

    vecs.push_back('{32'h00000001, 2'd0, 32'h3F800000, 1'b0, 11});
    vecs.push_back('{32'h80000000, 2'd0, 32'hCF000000, 1'b0, 3});
    vecs.push_back('{32'hFFFFFFFF, 2'd0, 32'hBF800000, 1'b0, 11});
    vecs.push_back('{32'h01000001, 2'd0, 32'h4B800000, 1'b1, 5});
    vecs.push_back('{32'h01000001, 2'd1, 32'h4B800000, 1'b1, 5});
    vecs.push_back('{32'h01000001, 2'd2, 32'h4B800001, 1'b1, 5});
    vecs.push_back('{32'h01000001, 2'd3, 32'h4B800000, 1'b1, 5});
    vecs.push_back('{32'hFEFFFFFF, 2'd2, 32'hCB800000, 1'b1, 5});
    vecs.push_back('{32'hFEFFFFFF, 2'd3, 32'hCB800001, 1'b1, 5});
    vecs.push_back('{32'h7FFFFFFF, 2'd0, 32'h4F000000, 1'b1, 4});
    vecs.push_back('{32'h7FFFFFFF, 2'd1, 32'h4EFFFFFF, 1'b1, 4});
    vecs.push_back('{32'h00000000, 2'd0, 32'h00000000, 1'b0, 2});
    vecs.push_back('{32'h00000005, 2'd0, 32'h40A00000, 1'b0, 11});
    vecs.push_back('{32'h01000003, 2'd0, 32'h4B800002, 1'b1, 5});

    #12;
    check("reset_valid", 32'(Valid_SO), 0);
    check("reset_result", Result_DO, 0);
    check("reset_inexact", 32'(Inexact_SO), 0);
    check("reset_busy", 32'(Busy_SO), 0);
    #2 Rst_RBI = 1'b1;
    @(posedge Clk_CI); #1;
    check("reset_ready", 32'(Ready_SO), 1);

    foreach (vecs[i]) begin
      convert(vecs[i].op, vecs[i].rm, r, x, l, bok);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_inexact", i), 32'(x), 32'(vecs[i].inx));
      check($sformatf("vec%0d_latency", i), 32'(l), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), 32'(bok), 1);
      check($sformatf("vec%0d_idle_after", i), {30'b0, Ready_SO, Busy_SO}, 32'h2);
    end

    for (int n = 0; n < 300; n++) begin
      logic [31:0] op;
      logic [1:0]  rm;
      op = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) op = -op;
      rm = 2'($urandom);
      model(op, rm, mr, mx, ml);
      convert(op, rm, r, x, l, bok);
      check($sformatf("rnd%0d_result op=%h rm=%0d", n, op, rm), r, mr);
      check($sformatf("rnd%0d_inexact op=%h", n, op), 32'(x), 32'(mx));
      check($sformatf("rnd%0d_latency op=%h", n, op), 32'(l), 32'(ml));
    end

    // Back-pressure: result held while the consumer stalls.
    Ready_SI = 1'b0;
    convert(32'h00000000, 2'd0, r, x, l, bok);
    check("hold_latency", 32'(l), 2);
    stable_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk_CI); #1;
      if (!Valid_SO || Result_DO !== r || Ready_SO || Inexact_SO !== x) stable_bad++;
    end
    check("hold_stable", 32'(stable_bad), 0);
    Ready_SI = 1'b1;
    @(posedge Clk_CI); #1;
    check("hold_release_ready", 32'(Ready_SO), 1);
    check("hold_release_valid", 32'(Valid_SO), 0);

    // Put a nonzero result in place so "keeps last value" is observable.
    convert(32'h00000003, 2'd0, r, x, l, bok);
    prev = Result_DO;
    check("pre_flush_result", prev, 32'h40400000);

    Operand_a_DI = 32'h00000001; RM_SI = 2'd0; Valid_SI = 1'b1;
    @(posedge Clk_CI); #1;
    Valid_SI = 1'b0;
    @(posedge Clk_CI); #1;
    @(posedge Clk_CI); #1;
    Flush_SI = 1'b1;
    #1;
    check("flush_ready_low", 32'(Ready_SO), 0);
    check("flush_busy_before", 32'(Busy_SO), 1);
    @(posedge Clk_CI); #1;
    Flush_SI = 1'b0;
    check("flush_busy_after", 32'(Busy_SO), 0);
    check("flush_result_kept", Result_DO, prev);
    check("flush_inexact", 32'(Inexact_SO), 0);
    // Flush together with Valid_SI in IDLE must not accept.
    Flush_SI = 1'b1; Valid_SI = 1'b1; Operand_a_DI = 32'h00000007;
    @(posedge Clk_CI); #1;
    Flush_SI = 1'b0; Valid_SI = 1'b0;
    check("flush_no_accept", 32'(Busy_SO), 0);
    stable_bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (Valid_SO || Busy_SO) stable_bad++;
      @(posedge Clk_CI); #1;
    end
    check("flush_no_valid", 32'(stable_bad), 0);
    convert(32'h00000005, 2'd0, r, x, l, bok);
    check("post_flush_result", r, 32'h40A00000);
    check("post_flush_latency", 32'(l), 11);

    // Asynchronous reset in the middle of a conversion.
    Operand_a_DI = 32'h00000001; RM_SI = 2'd0; Valid_SI = 1'b1;
    @(posedge Clk_CI); #1;
    Valid_SI = 1'b0;
    @(posedge Clk_CI); #1;
    #2 Rst_RBI = 1'b0;
    #1;
    check("midrst_valid", 32'(Valid_SO), 0);
    check("midrst_result", Result_DO, 0);
    check("midrst_inexact", 32'(Inexact_SO), 0);
    check("midrst_busy", 32'(Busy_SO), 0);
    #3 Rst_RBI = 1'b1;
    @(posedge Clk_CI); #1;
    stable_bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (Valid_SO || Busy_SO) stable_bad++;
      @(posedge Clk_CI); #1;
    end
    check("midrst_no_result", 32'(stable_bad), 0);
    convert(32'h7FFFFFFF, 2'd1, r, x, l, bok);
    check("post_rst_result", r, 32'h4EFFFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
